// File: rtl/axis_tone_seq.sv
// axis_tone_seq - tone sequencer for the DSM DAC signal path.
//
// Holds a table of STEPS tone steps {div, dur, shift} and walks through it,
// configuring the sine generator (divider, restart, enable) step by step.
// Generator samples seen during RUN are attenuated by an arithmetic right
// shift and placed in a single AXI-Stream output register; a sample that
// overwrites a still-pending one sets the sticky overrun flag.
//
// Ports:
//   aclk, arst_n        clock; synchronous active-low reset
//   cfg_we/addr/div/dur/shift
//                       table write port (dur==0 marks end of sequence)
//   start, stop, loop   sequence control (start/stop pulses, loop level)
//   gen_sample, gen_tdata
//                       generator sample strobe and signed sample
//   gen_div, gen_en, gen_restart
//                       generator configuration for the current step
//   m_axis_tdata/tvalid/tready
//                       scaled sample stream to the modulator
//   busy, step_idx, done, overrun
//                       status
module axis_tone_seq #(
  parameter int unsigned STEPS = 8,
  parameter int unsigned DIV_W = 16,
  parameter int unsigned DUR_W = 16
) (
  input  logic                     aclk,
  input  logic                     arst_n,
  input  logic                     cfg_we,
  input  logic [$clog2(STEPS)-1:0] cfg_addr,
  input  logic [DIV_W-1:0]         cfg_div,
  input  logic [DUR_W-1:0]         cfg_dur,
  input  logic [1:0]               cfg_shift,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic                     gen_sample,
  input  logic [15:0]              gen_tdata,
  output logic [DIV_W-1:0]         gen_div,
  output logic                     gen_en,
  output logic                     gen_restart,
  output logic [15:0]              m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     busy,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     done,
  output logic                     overrun
);

  localparam int unsigned AW = $clog2(STEPS);
  localparam logic [AW-1:0] IDX_LAST = AW'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  // Step table
  logic [DIV_W-1:0] div_tab   [STEPS];
  logic [DUR_W-1:0] dur_tab   [STEPS];
  logic [1:0]       shift_tab [STEPS];

  // Working registers for the active step
  logic [DUR_W-1:0] dur_q;
  logic [1:0]       shift_q;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    idx_d;
  logic             done_d;
  logic             load;
  logic             end_seq;
  logic             capture;

  assign capture = (state_q == S_RUN) && gen_sample;
  assign gen_en  = (state_q == S_RUN);
  assign busy    = (state_q != S_IDLE);
  // An entry with dur==0 ends the sequence instead of starting a step, so
  // the generator is only restarted for real steps.
  assign gen_restart = (state_q == S_LOAD) && (dur_tab[step_idx] != '0) && !stop;

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      for (int unsigned i = 0; i < STEPS; i++) begin
        div_tab[i]   <= '0;
        dur_tab[i]   <= '0;
        shift_tab[i] <= '0;
      end
    end else if (cfg_we) begin
      div_tab[cfg_addr]   <= cfg_div;
      dur_tab[cfg_addr]   <= cfg_dur;
      shift_tab[cfg_addr] <= cfg_shift;
    end
  end

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      state_q  <= S_IDLE;
      step_idx <= '0;
      cnt_q    <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_idx <= idx_d;
      cnt_q    <= cnt_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = step_idx;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    load    = 1'b0;
    end_seq = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        load  = 1'b1;
        cnt_d = '0;
        if (dur_tab[step_idx] == '0) begin
          end_seq = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (gen_sample) begin
          if (cnt_q == dur_q - DUR_W'(1)) begin
            if (step_idx == IDX_LAST) begin
              end_seq = 1'b1;
            end else begin
              idx_d   = step_idx + AW'(1);
              state_d = S_LOAD;
            end
          end else begin
            cnt_d = cnt_q + DUR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (end_seq) begin
      if (loop) begin
        idx_d   = '0;
        state_d = S_LOAD;
      end else begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end

    // Abort wins over everything; the index is left where it was.
    if (stop) begin
      state_d = S_IDLE;
      idx_d   = step_idx;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      gen_div       <= '0;
      dur_q         <= '0;
      shift_q       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (load) begin
        gen_div <= div_tab[step_idx];
        dur_q   <= dur_tab[step_idx];
        shift_q <= shift_tab[step_idx];
      end
      // A new sample always wins the register; it is only an overrun when
      // the pending sample is not being taken in the same cycle.
      if (capture) begin
        m_axis_tdata  <= $signed(gen_tdata) >>> shift_q;
        m_axis_tvalid <= 1'b1;
        if (m_axis_tvalid && !m_axis_tready) begin
          overrun <= 1'b1;
        end
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
